phy_serdes_lanes: RTL and testbench

Parametrised single-clock serialiser/deserialiser for the PHY. It replaces the fixed two-lane, 8-bit, multi-clock TX/RX pair with LANES lanes of W-bit words, one bit per clock per lane. Each RX lane has comma-based word alignment and a lock state machine. A runtime loopback select chooses between an internal TX→RX path and the external serial inputs. The block sits between the parallel striping logic and the serial line.

---
 rtl/phy_serdes_lanes.sv | 105 ++++++++++
 tb/tb_phy_serdes_lanes.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/phy_serdes_lanes.sv
// phy_serdes_lanes: multi-lane single-clock serialiser/deserialiser with comma alignment and loopback
module phy_serdes_lanes #(
  parameter int W = 8,
  parameter int LANES = 2,
  parameter logic [W-1:0] COMMA = 8'hBC,
  parameter int LOCK_CNT = 4
) (
  input  logic               clk_f,
  input  logic               reset,
  input  logic [LANES*W-1:0] data_in,
  input  logic [LANES-1:0]   valid_in,
  output logic               word_ready,
  input  logic               lpbk,
  input  logic [LANES-1:0]   serial_in,
  output logic [LANES-1:0]   serial_out,
  output logic [LANES*W-1:0] data_out,
  output logic [LANES-1:0]   valid_out,
  output logic [LANES-1:0]   active
);
  localparam int CW = $clog2(W);
  localparam int KW = $clog2(LOCK_CNT + 1);
  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] ALIGNING = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;

  logic [CW-1:0] tx_cnt_q, tx_cnt_d;

  assign word_ready = (tx_cnt_q == CW'(W - 1)) && reset;
  assign tx_cnt_d = (tx_cnt_q == CW'(W - 1)) ? '0 : tx_cnt_q + CW'(1);

  // Shared TX bit counter: one word boundary every W edges for all lanes
  always_ff @(posedge clk_f) begin
    if (!reset) tx_cnt_q <= '0;
    else tx_cnt_q <= tx_cnt_d;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, nw, dout_q, dout_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [KW-1:0] cc_q, cc_d;
    logic [1:0] st_q, st_d;
    logic v_q, v_d, act_q, b, done, is_comma;

    assign tx_sh_d = word_ready ? (valid_in[k] ? data_in[k*W +: W] : COMMA) : {tx_sh_q[W-2:0], 1'b0};
    assign serial_out[k] = tx_sh_q[W-1];
    assign b = lpbk ? serial_out[k] : serial_in[k];
    assign nw = {rx_sh_q[W-2:0], b};
    assign done = rx_cnt_q == CW'(W - 1);
    assign is_comma = nw == COMMA;

    // Lock FSM: free comma search when unlocked, word-aligned comma counting while aligning
    always_comb begin
      st_d = st_q;
      cc_d = cc_q;
      rx_cnt_d = done ? '0 : rx_cnt_q + CW'(1);
      v_d = 1'b0;
      dout_d = dout_q;
      if (st_q == UNLOCKED) begin
        if (is_comma) begin
          rx_cnt_d = '0;
          cc_d = KW'(1);
          st_d = (LOCK_CNT == 1) ? LOCKED : ALIGNING;
        end
      end else if (st_q == ALIGNING) begin
        if (done && is_comma) begin
          cc_d = cc_q + KW'(1);
          st_d = (cc_q + KW'(1) == KW'(LOCK_CNT)) ? LOCKED : ALIGNING;
        end else if (done) begin
          cc_d = '0;
          st_d = UNLOCKED;
        end
      end else begin
        v_d = done ? !is_comma : v_q;
        dout_d = (done && !is_comma) ? nw : dout_q;
      end
    end

    // Per-lane TX shifter and RX state registers
    always_ff @(posedge clk_f) begin
      if (!reset) begin
        tx_sh_q <= '0;
        rx_sh_q <= '0;
        rx_cnt_q <= '0;
        cc_q <= '0;
        st_q <= UNLOCKED;
        v_q <= 1'b0;
        dout_q <= '0;
        act_q <= 1'b0;
      end else begin
        tx_sh_q <= tx_sh_d;
        rx_sh_q <= nw;
        rx_cnt_q <= rx_cnt_d;
        cc_q <= cc_d;
        st_q <= st_d;
        v_q <= v_d;
        dout_q <= dout_d;
        act_q <= st_d == LOCKED;
      end
    end

    assign data_out[k*W +: W] = dout_q;
    assign valid_out[k] = v_q;
    assign active[k] = act_q;
  end
endmodule

// File: tb/tb_phy_serdes_lanes.sv
// tb_phy_serdes_lanes: directed self-checking bench for phy_serdes_lanes
module tb_phy_serdes_lanes;
  logic clk_f = 1'b0;
  logic reset;
  logic [15:0] data_in;
  logic [1:0] valid_in;
  logic word_ready;
  logic lpbk;
  logic [1:0] serial_in;
  logic [1:0] serial_out;
  logic [15:0] data_out;
  logic [1:0] valid_out;
  logic [1:0] active;
  int errors = 0;
  int checks = 0;
  logic [7:0] bc = 8'hBC;

  phy_serdes_lanes dut (
    .clk_f(clk_f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .word_ready(word_ready), .lpbk(lpbk), .serial_in(serial_in),
    .serial_out(serial_out), .data_out(data_out), .valid_out(valid_out), .active(active)
  );

  always #5 clk_f = ~clk_f;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_f);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = 16'($urandom);
      valid_in = 2'($urandom);
      serial_in = 2'($urandom);
      lpbk = 1'($urandom);
      tick();
      checks++;
      if ({serial_out, data_out, valid_out, active, word_ready} !== 23'd0) begin
        errors++;
        $display("FAIL reset: so=%b do=%h vo=%b act=%b wr=%b required all zero", serial_out, data_out, valid_out, active, word_ready);
      end
    end
  endtask

  task automatic test_lock;
    logic [1:0] exp_so;
    reset = 1'b0;
    lpbk = 1'b1;
    valid_in = 2'b00;
    data_in = 16'h0;
    serial_in = 2'b00;
    tick();
    reset = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      exp_so = (n < 8) ? 2'b00 : {2{bc[7 - ((n - 8) % 8)]}};
      checks++;
      if (serial_out !== exp_so) begin
        errors++;
        $display("FAIL lock_serial n=%0d: got %b required %b", n, serial_out, exp_so);
      end
      checks++;
      if (word_ready !== (n % 8 == 7)) begin
        errors++;
        $display("FAIL lock_word_ready n=%0d: got %b required %b", n, word_ready, n % 8 == 7);
      end
      checks++;
      if (active !== ((n >= 40) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL lock_active n=%0d: got %b required %b", n, active, (n >= 40) ? 2'b11 : 2'b00);
      end
      checks++;
      if (valid_out !== 2'b00) begin
        errors++;
        $display("FAIL lock_valid n=%0d: got %b required 00", n, valid_out);
      end
    end
  endtask

  task automatic test_data;
    int w = 0;
    while (!word_ready && w < 16) begin
      tick();
      w++;
    end
    checks++;
    if (word_ready !== 1'b1) begin
      errors++;
      $display("FAIL data_wait: word_ready got %b required 1", word_ready);
    end
    data_in = {8'hC3, 8'h5A};
    valid_in = 2'b11;
    tick();
    valid_in = 2'b00;
    data_in = 16'h0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 8) begin
        checks++;
        if (valid_out !== 2'b00) begin
          errors++;
          $display("FAIL data_pre i=%0d: valid got %b required 00", i, valid_out);
        end
      end else if (i < 16) begin
        checks++;
        if (data_out !== 16'hC35A || valid_out !== 2'b11) begin
          errors++;
          $display("FAIL data_word i=%0d: got %h/%b required c35a/11", i, data_out, valid_out);
        end
      end else begin
        checks++;
        if (data_out !== 16'hC35A || valid_out !== 2'b00) begin
          errors++;
          $display("FAIL data_idle: got %h/%b required c35a/00", data_out, valid_out);
        end
      end
    end
  endtask

  task automatic test_comma_data;
    int w = 0;
    while (!word_ready && w < 16) begin
      tick();
      w++;
    end
    checks++;
    if (word_ready !== 1'b1) begin
      errors++;
      $display("FAIL comma_wait: word_ready got %b required 1", word_ready);
    end
    data_in = {8'hBC, 8'h11};
    valid_in = 2'b11;
    tick();
    valid_in = 2'b00;
    data_in = 16'h0;
    for (int i = 1; i <= 7; i++) tick();
    checks++;
    if (data_out !== 16'hC35A || valid_out !== 2'b00) begin
      errors++;
      $display("FAIL comma_pre: got %h/%b required c35a/00", data_out, valid_out);
    end
    tick();
    checks++;
    if (data_out !== 16'hC311 || valid_out !== 2'b01) begin
      errors++;
      $display("FAIL comma_data: got %h/%b required c311/01", data_out, valid_out);
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (active !== 2'b11) begin
      errors++;
      $display("FAIL midrst_pre: active got %b required 11", active);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({serial_out, data_out, valid_out, active, word_ready} !== 23'd0) begin
      errors++;
      $display("FAIL midrst: so=%b do=%h vo=%b act=%b wr=%b required all zero", serial_out, data_out, valid_out, active, word_ready);
    end
    reset = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      checks++;
      if (active !== ((n >= 40) ? 2'b11 : 2'b00) || valid_out !== 2'b00) begin
        errors++;
        $display("FAIL midrst_relock n=%0d: act/vo got %b/%b required %b/00", n, active, valid_out, (n >= 40) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_alignment_break;
    logic [7:0] words [7];
    logic [7:0] cur;
    words = '{8'hBC, 8'hBC, 8'h00, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    reset = 1'b0;
    lpbk = 1'b0;
    serial_in = 2'b00;
    valid_in = 2'b00;
    tick();
    reset = 1'b1;
    for (int n = 1; n <= 56; n++) begin
      cur = words[(n - 1) / 8];
      serial_in = {1'b0, cur[7 - ((n - 1) % 8)]};
      tick();
      checks++;
      if (active !== ((n >= 56) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL align_active n=%0d: got %b required %b", n, active, (n >= 56) ? 2'b01 : 2'b00);
      end
      checks++;
      if (valid_out !== 2'b00) begin
        errors++;
        $display("FAIL align_valid n=%0d: got %b required 00", n, valid_out);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    lpbk = 1'b0;
    data_in = 16'h0;
    valid_in = 2'b00;
    serial_in = 2'b00;
    test_reset();
    test_lock();
    test_data();
    test_comma_data();
    test_mid_reset();
    test_alignment_break();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
